// File: rtl/z80_bus_initiator.sv
// Z80-style bus initiator: single commands to T1/T2/TW/T3 machine cycles.
// Optional macro WAIT_TIMEOUT_EN bounds time spent in TW and flags rsp_err.
module z80_bus_initiator #(
    parameter int TDIV    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        CLK_24MHz,
    input  logic        RES,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic        cmd_mem,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] A,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic [7:0]  D_IN,
    output logic        IORQ,
    output logic        MREQ,
    output logic        RD,
    output logic        WR,
    input  logic        WAIT,
    output logic        BCLK
);

    localparam int CW = (TDIV > 2) ? $clog2(TDIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TW,
        S_T3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          tick;
    logic          accept;
    logic          done;
    logic          tmo_fire;
    logic          wr_q, mem_q, wr_nxt, mem_nxt;
    logic          wait_s1, wait_s2;

    logic [15:0]   a_nxt;
    logic [7:0]    dout_nxt;
    logic          doe_nxt;
    logic [7:0]    rdata_nxt;
    logic          bus_nxt;
    logic          iorq_nxt, mreq_nxt, rd_nxt, wr_n_nxt;
    logic          bclk_nxt;

    assign tick   = (cnt == CW'(TDIV - 1));
    assign accept = cmd_valid & cmd_ready;
    assign done   = (state == S_T3) && tick;

`ifdef WAIT_TIMEOUT_EN
    localparam int TWW = $clog2(TIMEOUT + 1);

    logic [TWW-1:0] tw_cnt;
    logic           err_q;

    assign tmo_fire = (state == S_TW) && !wait_s2 &&
                      (tw_cnt == TWW'(TIMEOUT - 1));

    // Count elapsed TW T-states and remember a timeout abort
    always_ff @(posedge CLK_24MHz) begin
        if (!RES) begin
            tw_cnt  <= '0;
            err_q   <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            if (state == S_T2)
                tw_cnt <= '0;
            else if (state == S_TW && tick)
                tw_cnt <= tw_cnt + 1'b1;
            if (accept)
                err_q <= 1'b0;
            else if (tick && tmo_fire)
                err_q <= 1'b1;
            rsp_err <= done & err_q;
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    // State, divider, synchroniser and registered bus outputs
    always_ff @(posedge CLK_24MHz) begin
        if (!RES) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            mem_q     <= 1'b0;
            wait_s1   <= 1'b1;
            wait_s2   <= 1'b1;
            A         <= '0;
            D_OUT     <= '0;
            D_OE      <= 1'b0;
            IORQ      <= 1'b1;
            MREQ      <= 1'b1;
            RD        <= 1'b1;
            WR        <= 1'b1;
            BCLK      <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wr_q      <= wr_nxt;
            mem_q     <= mem_nxt;
            wait_s1   <= WAIT;
            wait_s2   <= wait_s1;
            A         <= a_nxt;
            D_OUT     <= dout_nxt;
            D_OE      <= doe_nxt;
            IORQ      <= iorq_nxt;
            MREQ      <= mreq_nxt;
            RD        <= rd_nxt;
            WR        <= wr_n_nxt;
            BCLK      <= bclk_nxt;
            cmd_ready <= (state_nxt == S_IDLE);
            rsp_valid <= done;
            rsp_rdata <= rdata_nxt;
        end
    end

    // Next state and T-state divider; transitions only on a tick
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        if (state != S_IDLE)
            cnt_nxt = tick ? '0 : cnt + 1'b1;
        unique case (state)
            S_IDLE: if (accept) state_nxt = S_T1;
            S_T1:   if (tick) state_nxt = S_T2;
            S_T2: begin
                if (tick)
                    state_nxt = (!mem_q || !wait_s2) ? S_TW : S_T3;
            end
            S_TW: begin
                if (tick && (wait_s2 || tmo_fire))
                    state_nxt = S_T3;
            end
            S_T3:   if (tick) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs
    always_comb begin
        wr_nxt    = wr_q;
        mem_nxt   = mem_q;
        a_nxt     = A;
        dout_nxt  = D_OUT;
        doe_nxt   = D_OE;
        rdata_nxt = rsp_rdata;
        if (accept) begin
            wr_nxt   = cmd_wr;
            mem_nxt  = cmd_mem;
            a_nxt    = cmd_addr;
            dout_nxt = cmd_wdata;
            doe_nxt  = cmd_wr;
        end
        if (done) begin
            doe_nxt = 1'b0;
            if (!wr_q)
                rdata_nxt = D_IN;
        end
        bus_nxt  = (state_nxt == S_T2) || (state_nxt == S_TW) ||
                   (state_nxt == S_T3);
        iorq_nxt = !(bus_nxt && !mem_q);
        mreq_nxt = !(bus_nxt && mem_q);
        rd_nxt   = !(bus_nxt && !wr_q);
        wr_n_nxt = !(bus_nxt && wr_q);
        bclk_nxt = (state_nxt != S_IDLE) && (cnt_nxt < CW'(TDIV / 2));
    end

endmodule

// File: tb/tb_z80_bus_initiator.sv
// Bench for z80_bus_initiator: random commands, scoreboard of expected
// completions, WAIT responder, mid-cycle reset and optional timeout.
module tb_z80_bus_initiator;

    localparam int TDIV = 4;
`ifdef WAIT_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 64;
`endif

    logic        clk = 1'b0;
    logic        RES = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic        cmd_mem = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [15:0] A;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic [7:0]  D_IN = '0;
    logic        IORQ, MREQ, RD, WR;
    logic        WAIT = 1'b1;
    logic        BCLK;

    z80_bus_initiator #(.TDIV(TDIV), .TIMEOUT(TMO)) dut (
        .CLK_24MHz(clk),
        .RES(RES),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr),
        .cmd_mem(cmd_mem),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .A(A),
        .D_OUT(D_OUT),
        .D_OE(D_OE),
        .D_IN(D_IN),
        .IORQ(IORQ),
        .MREQ(MREQ),
        .RD(RD),
        .WR(WR),
        .WAIT(WAIT),
        .BCLK(BCLK)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic        mem;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        err;
        int          acc;
        int          lat;
        int          slow;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] model_rdata = '0;
    int         slow_cnt = 0;
    int         bclk_cnt = 0;
    bit         pat_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Monitor: accumulates per-transaction bus observations, pops on rsp_valid
    always @(negedge clk) begin
        if (RES) begin
            if (q.size() > 0) begin
                if (BCLK) bclk_cnt++;
                if (!IORQ || !MREQ || !RD || !WR) begin
                    slow_cnt++;
                    if (IORQ !== q[0].mem || MREQ !== !q[0].mem ||
                        RD !== q[0].wr || WR !== !q[0].wr)
                        pat_bad = 1;
                    if (D_OE !== q[0].wr) pat_bad = 1;
                    if (q[0].wr && D_OUT !== q[0].wdata) pat_bad = 1;
                end
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency", cyc - e.acc, e.lat);
                    chk("rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
                    chk("err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("strobe_low", slow_cnt, e.slow);
                    chk("bclk_high", bclk_cnt, e.lat / 2);
                    chk("addr", {16'd0, A}, {16'd0, e.addr});
                    chk("strobe_pattern", {31'd0, pat_bad}, 32'd0);
                    chk("doe_after", {31'd0, D_OE}, 32'd0);
                end
                slow_cnt = 0;
                bclk_cnt = 0;
                pat_bad  = 0;
            end
        end else begin
            slow_cnt = 0;
            bclk_cnt = 0;
            pat_bad  = 0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one command; k = ticks (from strobe fall) that see WAIT low
    task automatic run(input logic wr, input logic mem,
                       input logic [15:0] addr, input logic [7:0] wdata,
                       input logic [7:0] rdata, input int k);
        exp_t e;
        int   nat, ntw, n, fall;
        @(negedge clk);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_mem   = mem;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        D_IN      = rdata;
        if (k > 0) WAIT = 1'b0;
        nat = mem ? k : ((k > 1) ? k : 1);
        e.err = 1'b0;
        ntw = nat;
`ifdef WAIT_TIMEOUT_EN
        if (nat > TMO) begin
            ntw   = TMO;
            e.err = 1'b1;
        end
`endif
        if (!wr) model_rdata = rdata;
        e.addr  = addr;
        e.wr    = wr;
        e.mem   = mem;
        e.wdata = wdata;
        e.rdata = model_rdata;
        e.acc   = cyc + 1;
        e.lat   = (3 + ntw) * TDIV;
        e.slow  = (2 + ntw) * TDIV;
        q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = 16'($urandom);
        cmd_wdata = 8'($urandom);
        n = 0;
        while (IORQ && MREQ && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (IORQ && MREQ) begin
            chk("strobe_fall", 32'd0, 32'd1);
            WAIT = 1'b1;
            return;
        end
        fall = cyc;
        n = 0;
        while (cyc < fall + TDIV * k && !cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        WAIT = 1'b1;
    endtask

    initial begin
        int n;
        RES = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_strobes", {28'd0, IORQ, MREQ, RD, WR}, 32'hF);
        chk("rst_bus", {7'd0, D_OE, A, D_OUT}, 32'd0);
        chk("rst_rsp", {21'd0, BCLK, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
        RES = 1'b1;

        run(1'b1, 1'b0, 16'h00EF, 8'h5A, 8'h00, 0);
        run(1'b0, 1'b0, 16'h0020, 8'h00, 8'h04, 0);
        run(1'b0, 1'b1, 16'h8000, 8'h00, 8'hC3, 0);
        run(1'b0, 1'b0, 16'h0031, 8'h00, 8'h9E, 3);
        run(1'b1, 1'b1, 16'h1234, 8'hA5, 8'h77, 2);

        // Kill an I/O write while it sits in T2
        @(negedge clk);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_mem   = 1'b0;
        cmd_addr  = 16'h0042;
        cmd_wdata = 8'h3C;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (IORQ && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("kill_in_t2", {31'd0, IORQ}, 32'd0);
        RES = 1'b0;
        @(negedge clk);
        chk("kill_strobes", {28'd0, IORQ, MREQ, RD, WR}, 32'hF);
        chk("kill_doe", {31'd0, D_OE}, 32'd0);
        chk("kill_ready", {31'd0, cmd_ready}, 32'd1);
        chk("kill_rsp", {31'd0, rsp_valid}, 32'd0);
        model_rdata = 8'h00;
        RES = 1'b1;
        repeat (30) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            run(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
                8'($urandom), int'($urandom_range(0, 3)));
        end

`ifdef WAIT_TIMEOUT_EN
        run(1'b0, 1'b0, 16'h0055, 8'h00, 8'hE1, 100);
        run(1'b1, 1'b1, 16'h4000, 8'h19, 8'h00, 100);
        run(1'b0, 1'b1, 16'h4001, 8'h00, 8'h2D, 0);
`endif

        n = 0;
        while (q.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 32'd0);
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/z80_bus_initiator.md
Name: z80_bus_initiator

Overview:
- Z80-style bus master. Turns single-transaction commands from an internal requester (test sequencer, boot loader, DMA engine) into Z80 I/O and memory machine cycles.
- Drives the same signal set the CPLD decoder/mapper responds to: A, D, IORQ, MREQ, RD, WR, WAIT.
- Runs on the board clock and generates the bus clock from a T-state divider. Returns read data and completion to the requester.

Parameters:
- TDIV, 4: system clocks per T-state; legal range 2..16, even values only.
- TIMEOUT, 64: maximum T-states spent in TW before abort. Used only with WAIT_TIMEOUT_EN.

Ports:
- CLK_24MHz  in  1  system clock; all logic on the rising edge.
- RES  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  initiator idle; command accepted when cmd_valid & cmd_ready.
- cmd_wr  in  1  1 = write cycle, 0 = read cycle.
- cmd_mem  in  1  1 = memory cycle (MREQ), 0 = I/O cycle (IORQ).
- cmd_addr  in  16  bus address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-clock completion pulse.
- rsp_rdata  out  8  read data captured at the end of T3; holds until the next read completes.
- rsp_err  out  1  valid with rsp_valid; 1 = aborted by timeout.
- A  out  16  address bus.
- D_OUT  out  8  data bus output.
- D_OE  out  1  data bus output enable.
- D_IN  in  8  data bus input.
- IORQ, MREQ, RD, WR  out  1 each  active-low strobes.
- WAIT  in  1  active-low wait request, asynchronous to CLK_24MHz.
- BCLK  out  1  bus clock: high during the first TDIV/2 clocks of each T-state, low for the rest.

Behaviour:
- Reset: RES low at a rising edge forces the following, taking effect at that edge regardless of state:
  - state = IDLE; A = 0; D_OUT = 0; D_OE = 0
  - IORQ = MREQ = RD = WR = 1
  - BCLK = 0; cmd_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0
  - divider cleared
- Reset mid-cycle: strobes are released on the same edge, D_OE drops, and no rsp_valid is issued for the killed command.
- Divider:
  - counter 0..TDIV-1 runs only outside IDLE.
  - "tick" = counter == TDIV-1.
  - Counter restarts at 0 on command accept.
- WAIT path: two-flop synchroniser. The synchronised value is evaluated only on a tick.
- States: IDLE, T1, T2, TW, T3. All transitions out of T1/T2/TW/T3 occur on a tick.
- IDLE:
  - cmd_ready = 1.
  - On accept: A <= cmd_addr, D_OUT <= cmd_wdata, latch cmd_wr and cmd_mem, D_OE <= cmd_wr, cmd_ready <= 0, go to T1.
- T1: strobes all high; A and D_OUT stable.
- T1 -> T2: selected strobes go low on entry to T2.
  - IORQ for an I/O cycle, MREQ for a memory cycle.
  - RD for a read, WR for a write.
- T2 -> TW / T3:
  - I/O cycle: always goes to TW (one mandatory wait state).
  - Memory cycle: goes to TW if synchronised WAIT = 0, else to T3.
- TW: stays in TW while synchronised WAIT = 0; goes to T3 when it is 1.
- T3, last clock (tick):
  - rsp_rdata <= D_IN (reads only; writes leave it unchanged).
  - All strobes go high, D_OE <= 0, rsp_valid = 1 for one clock, rsp_err = 0.
  - Return to IDLE with cmd_ready = 1 on the same edge.
- A holds its last value in IDLE; it is not cleared after a cycle.
- Latency from the accept edge to the rsp_valid edge:
  - I/O cycle with no extra waits: 4*TDIV clocks.
  - Memory cycle with no waits: 3*TDIV clocks.
  - Each extra TW adds TDIV clocks.
- Strobe low duration:
  - I/O: 3*TDIV clocks (T2 + TW + T3).
  - Memory: 2*TDIV clocks (T2 + T3).
- cmd_valid while busy is ignored and must be held by the requester. Back-to-back commands may be accepted in the clock after rsp_valid.
- WAIT toggling outside T2/TW has no effect.

Optional Feature:
- Macro: WAIT_TIMEOUT_EN.
- When defined:
  - A T-state counter runs in TW.
  - When TIMEOUT consecutive TW T-states have elapsed, the initiator moves to T3 at the next tick regardless of WAIT.
  - Completion is the normal T3 sequence with rsp_err = 1 on the rsp_valid pulse. rsp_rdata is still updated from D_IN.
- When undefined: TW waits indefinitely, the counter is not built, and rsp_err is tied 0.

Test Plan:
- TDIV=4, I/O write cmd_addr=0x00EF, cmd_wdata=0x5A, WAIT=1 -> A=0x00EF and D_OUT=0x5A with D_OE=1 for 16 clocks; IORQ=WR=0 for 12 clocks; MREQ, RD stay 1; rsp_valid pulses 16 clocks after accept.
- TDIV=4, I/O read 0x0020, responder drives D_IN=0x04 -> IORQ=RD=0 for 12 clocks; D_OE stays 0; rsp_rdata=0x04; rsp_err=0.
- TDIV=4, memory read 0x8000, D_IN=0xC3, WAIT=1 -> MREQ=RD=0 for 8 clocks; rsp_valid after 12 clocks; rsp_rdata=0xC3.
- TDIV=4, I/O read with WAIT held 0 for 2 extra T-states -> strobe low 20 clocks; rsp_valid after 24 clocks; data captured correctly.
- RES pulled low during T2 of an I/O write -> at that edge all strobes = 1, D_OE = 0, cmd_ready = 1; no rsp_valid; a following command runs normally.
- WAIT_TIMEOUT_EN, TIMEOUT=4, WAIT stuck 0 on an I/O read -> cycle completes with rsp_valid=1, rsp_err=1; strobes released after T3.
